serial_alu_driver: RTL and testbench

SERIAL_ALU_DRIVER -- requirements
Module: serial_alu_driver

---
 rtl/serial_alu_driver.sv | 127 ++++++++++++
 tb/tb_serial_alu_driver.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_alu_driver.sv
// Bit-serial AND/OR/ADD/SUB(/SLT with SERIAL_ALU_SLT_EN) engine; done 33 edges after accept (34 for SLT, 1 for unsupported codes).
// No backpressure: start is sampled only in IDLE and ignored while busy; results are held until the next accept.
module serial_alu_driver (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] dataA,
   input  logic [31:0] dataB,
   input  logic [5:0]  Signal,
   output logic        busy,
   output logic        done,
   output logic [31:0] dataOut,
   output logic        carryOut,
   output logic        illegal
);

   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_SLT = 6'b101010;

`ifdef SERIAL_ALU_SLT_EN
   localparam logic SLT_EN = 1'b1;
   typedef enum logic [1:0] {IDLE, RUN, SETLT, DONE} state_t;
`else
   localparam logic SLT_EN = 1'b0;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

   state_t      state;
   logic [31:0] opA;
   logic [31:0] opB;
   logic [31:0] resReg;
   logic [5:0]  op;
   logic [4:0]  idx;
   logic        carry;
`ifdef SERIAL_ALU_SLT_EN
   logic        sltLess;
`endif

   logic aBit;
   logic bBit;
   logic sumBit;
   logic coutBit;
   logic resBit;

   function automatic logic isLegal(input logic [5:0] f);
      return (f == FN_AND) || (f == FN_OR) || (f == FN_ADD) || (f == FN_SUB) ||
             (SLT_EN && (f == FN_SLT));
   endfunction

   function automatic logic needsInvert(input logic [5:0] f);
      return (f == FN_SUB) || (SLT_EN && (f == FN_SLT));
   endfunction

   always_comb begin
      aBit    = opA[idx];
      bBit    = opB[idx] ^ needsInvert(op);
      sumBit  = aBit ^ bBit ^ carry;
      coutBit = (aBit & bBit) | (carry & (aBit ^ bBit));
      case (op)
         FN_AND:  resBit = aBit & opB[idx];
         FN_OR:   resBit = aBit | opB[idx];
         default: resBit = sumBit;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         dataOut  <= 32'd0;
         carryOut <= 1'b0;
         illegal  <= 1'b0;
         carry    <= 1'b0;
         idx      <= 5'd0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               // busy stays high through the done cycle, which is spent in IDLE
               busy <= start;
               if (start) begin
                  opA    <= dataA;
                  opB    <= dataB;
                  op     <= Signal;
                  carry  <= needsInvert(Signal);
                  idx    <= 5'd0;
                  resReg <= 32'd0;
                  state  <= isLegal(Signal) ? RUN : DONE;
               end
            end
            RUN: begin
               resReg[idx] <= resBit;
               carry       <= coutBit;
               idx         <= idx + 5'd1;
               if (idx == 5'd31) begin
`ifdef SERIAL_ALU_SLT_EN
                  // sign of the true difference: sum MSB corrected by overflow
                  sltLess <= sumBit ^ (carry ^ coutBit);
                  state   <= (op == FN_SLT) ? SETLT : DONE;
`else
                  state   <= DONE;
`endif
               end
            end
`ifdef SERIAL_ALU_SLT_EN
            SETLT: begin
               resReg <= {31'd0, sltLess};
               state  <= DONE;
            end
`endif
            DONE: begin
               done     <= 1'b1;
               dataOut  <= isLegal(op) ? resReg : 32'd0;
               carryOut <= ((op == FN_ADD) || (op == FN_SUB)) ? carry : 1'b0;
               illegal  <= !isLegal(op);
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_alu_driver.sv
// Bench for serial_alu_driver: directed vector table, mid-run reset, held-start sequence, random ops vs arithmetic model.
module tb_serial_alu_driver;

`ifdef SERIAL_ALU_SLT_EN
   localparam bit SLT_EN = 1'b1;
`else
   localparam bit SLT_EN = 1'b0;
`endif

   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_SLT = 6'b101010;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] dataA;
   logic [31:0] dataB;
   logic [5:0]  Signal;
   logic        busy;
   logic        done;
   logic [31:0] dataOut;
   logic        carryOut;
   logic        illegal;

   int nChecks = 0;
   int nFail   = 0;

   serial_alu_driver dut (
      .clk(clk), .rst(rst), .start(start), .dataA(dataA), .dataB(dataB), .Signal(Signal),
      .busy(busy), .done(done), .dataOut(dataOut), .carryOut(carryOut), .illegal(illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [5:0]  sig;
      logic [31:0] eOut;
      logic        eC;
      logic        eI;
      int          eLat;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference behaviour from plain integer arithmetic.
   function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [5:0] s,
                                 output logic [31:0] o, output logic c, output logic il,
                                 output int lat);
      o = 32'd0; c = 1'b0; il = 1'b0; lat = 33;
      case (s)
         FN_AND: o = a & b;
         FN_OR:  o = a | b;
         FN_ADD: {c, o} = {1'b0, a} + {1'b0, b};
         FN_SUB: begin o = a - b; c = (a >= b); end
         FN_SLT: begin
            if (SLT_EN) begin
               o = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
               lat = 34;
            end else begin
               il = 1'b1; lat = 1;
            end
         end
         default: begin il = 1'b1; lat = 1; end
      endcase
   endfunction

   // Called one step after a clock edge with the DUT idle.
   task automatic runOp(input logic [31:0] a, input logic [31:0] b, input logic [5:0] s,
                        input logic [31:0] eOut, input logic eC, input logic eI, input int eLat,
                        input string nm);
      int n;
      bit got;
      start = 1'b1; dataA = a; dataB = b; Signal = s;
      @(posedge clk); #1;
      start = 1'b0; dataA = $urandom; dataB = $urandom; Signal = 6'($urandom);
      chk({nm, " busy@accept"}, 32'(busy), 32'd1);
      n = 0; got = 1'b0;
      while (n < 60 && !got) begin
         @(posedge clk); #1;
         n++;
         if (done) got = 1'b1;
      end
      if (!got) begin
         chk({nm, " done timeout"}, 32'd0, 32'd1);
      end else begin
         chk({nm, " latency"}, 32'(n), 32'(eLat));
         chk({nm, " dataOut"}, dataOut, eOut);
         chk({nm, " carryOut"}, 32'(carryOut), 32'(eC));
         chk({nm, " illegal"}, 32'(illegal), 32'(eI));
         chk({nm, " busy@done"}, 32'(busy), 32'd1);
         @(posedge clk); #1;
         chk({nm, " done pulse width"}, 32'(done), 32'd0);
         chk({nm, " busy after"}, 32'(busy), 32'd0);
         chk({nm, " dataOut held"}, dataOut, eOut);
      end
   endtask

   initial begin
      logic [31:0] a, b, eo, a0, b0, a1, b1;
      logic [5:0]  s;
      logic        ec, ei;
      int          el, nDone, nDoneFirst, doneAt;
      logic [5:0]  codes[6];

      vecs[0] = '{32'hFFFFFFFF, 32'h00000001, FN_ADD, 32'h00000000, 1'b1, 1'b0, 33};
      vecs[1] = '{32'h00000005, 32'h00000007, FN_SUB, 32'hFFFFFFFE, 1'b0, 1'b0, 33};
      vecs[2] = '{32'hFFFFFFFD, 32'h00000002, FN_SLT, SLT_EN ? 32'd1 : 32'd0, 1'b0, !SLT_EN,
                  SLT_EN ? 34 : 1};
      vecs[3] = '{32'h7FFFFFFF, 32'h80000000, FN_SLT, 32'h00000000, 1'b0, !SLT_EN,
                  SLT_EN ? 34 : 1};
      vecs[4] = '{32'h12345678, 32'h9ABCDEF0, 6'b000000, 32'h00000000, 1'b0, 1'b1, 1};
      vecs[5] = '{32'hF0F0F0F0, 32'hFF00FF00, FN_AND, 32'hF000F000, 1'b0, 1'b0, 33};
      vecs[6] = '{32'hF0F0F0F0, 32'hFF00FF00, FN_OR,  32'hFFF0FFF0, 1'b0, 1'b0, 33};

      rst = 1'b1; start = 1'b1; dataA = 32'hDEADBEEF; dataB = 32'h1; Signal = FN_ADD;
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset dataOut", dataOut, 32'd0);
      chk("reset carryOut", 32'(carryOut), 32'd0);
      chk("reset illegal", 32'(illegal), 32'd0);
      rst = 1'b0; start = 1'b0;

      for (int i = 0; i < 7; i++)
         runOp(vecs[i].a, vecs[i].b, vecs[i].sig, vecs[i].eOut, vecs[i].eC, vecs[i].eI,
               vecs[i].eLat, $sformatf("vec%0d", i));

      // Reset while the ADD is at bit index 10 must abort silently.
      start = 1'b1; dataA = 32'h12345678; dataB = 32'h11111111; Signal = FN_ADD;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst busy", 32'(busy), 32'd0);
      chk("midrst done", 32'(done), 32'd0);
      chk("midrst dataOut", dataOut, 32'd0);
      chk("midrst carryOut", 32'(carryOut), 32'd0);
      chk("midrst illegal", 32'(illegal), 32'd0);
      nDone = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (done || busy) nDone++;
      end
      chk("midrst no done", 32'(nDone), 32'd0);
      runOp(32'h80000000, 32'h80000000, FN_ADD, 32'h00000000, 1'b1, 1'b0, 33, "postrst add");

      // start held high with operands changing every cycle.
      a0 = $urandom; b0 = $urandom;
      start = 1'b1; dataA = a0; dataB = b0; Signal = FN_ADD;
      @(posedge clk); #1;
      dataA = $urandom; dataB = $urandom;
      a1 = 32'd0; b1 = 32'd0;
      nDone = 0; nDoneFirst = 0; doneAt = -1;
      for (int c = 1; c <= 70; c++) begin
         @(posedge clk); #1;
         if (done) begin
            nDone++;
            if (c <= 33) nDoneFirst++;
            if (doneAt < 0) begin
               doneAt = c;
               chk("held first result", dataOut, a0 + b0);
            end else begin
               chk("held second result", dataOut, a1 + b1);
               chk("held second at", 32'(c), 32'd67);
            end
         end
         if (c == 34) begin
            chk("held second accept busy", 32'(busy), 32'd1);
            start = 1'b0;
         end
         dataA = $urandom; dataB = $urandom;
         if (c == 33) begin a1 = dataA; b1 = dataB; end
      end
      chk("held done at", 32'(doneAt), 32'd33);
      chk("held single done first op", 32'(nDoneFirst), 32'd1);
      chk("held total dones", 32'(nDone), 32'd2);

      codes = '{FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT, 6'd0};
      for (int i = 0; i < 40; i++) begin
         a = $urandom; b = $urandom;
         if (i % 7 == 0) b = a;
         if (i % 11 == 3) a = 32'h80000000;
         codes[5] = 6'($urandom_range(0, 63));
         s = codes[$urandom_range(0, 5)];
         model(a, b, s, eo, ec, ei, el);
         runOp(a, b, s, eo, ec, ei, el, $sformatf("rand%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
